// File: rtl/timer_mmio.sv
`default_nettype none
// ============================================================================
// Module   : timer_mmio
// Brief    : Memory-mapped prescaled 32-bit timer with compare match and irq.
// Revision : 1.0 - initial release
// ============================================================================
module timer_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [31:0] addr,
    input  logic [3:0]  select,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_o
);

    localparam logic [1:0] c_reg_ctrl    = 2'd0;
    localparam logic [1:0] c_reg_count   = 2'd1;
    localparam logic [1:0] c_reg_compare = 2'd2;
    localparam logic [1:0] c_reg_status  = 2'd3;

    logic        r_enable;
    logic        r_auto_reload;
    logic        r_irq_en;
    logic [15:0] r_prescale;
    logic [15:0] r_pre_cnt;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_match;

    logic        w_hit;
    logic        w_wr;
    logic        w_rd;
    logic [1:0]  w_sel;
    logic [31:0] w_mask;
    logic [31:0] w_ctrl;
    logic [31:0] w_ctrl_new;
    logic [31:0] w_count_new;
    logic [31:0] w_compare_new;
    logic [31:0] w_rdata;
    logic        w_tick;
    logic        w_eq;
    logic        w_unused;

    assign w_hit  = ram_en && (addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr   = w_hit && write_en;
    assign w_rd   = w_hit && read_en && !write_en;
    assign w_sel  = addr[3:2];
    assign w_mask = {{8{select[3]}}, {8{select[2]}}, {8{select[1]}}, {8{select[0]}}};

    assign w_ctrl        = {r_prescale, 13'd0, r_irq_en, r_auto_reload, r_enable};
    assign w_ctrl_new    = (w_ctrl    & ~w_mask) | (data_i & w_mask);
    assign w_count_new   = (r_count   & ~w_mask) | (data_i & w_mask);
    assign w_compare_new = (r_compare & ~w_mask) | (data_i & w_mask);

    // A tick fires on the cycle the prescaler sits at its terminal value.
    assign w_tick = r_enable && (r_pre_cnt == r_prescale);
    assign w_eq   = (r_count == r_compare);

    assign w_unused = &{1'b0, addr[1:0], w_ctrl_new[15:3]};

    always_comb begin
        w_rdata = 32'd0;
        case (w_sel)
            c_reg_ctrl:    w_rdata = w_ctrl;
            c_reg_count:   w_rdata = r_count;
            c_reg_compare: w_rdata = r_compare;
            c_reg_status:  w_rdata = {31'd0, r_match};
            default:       w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable      <= 1'b0;
            r_auto_reload <= 1'b0;
            r_irq_en      <= 1'b0;
            r_prescale    <= 16'd0;
            r_pre_cnt     <= 16'd0;
            r_count       <= 32'd0;
            r_compare     <= 32'd0;
            r_match       <= 1'b0;
            data_o        <= 32'd0;
        end else begin
            data_o <= w_rd ? w_rdata : 32'd0;

            if (w_wr && (w_sel == c_reg_ctrl)) begin
                r_enable      <= w_ctrl_new[0];
                r_auto_reload <= w_ctrl_new[1];
                r_irq_en      <= w_ctrl_new[2];
                r_prescale    <= w_ctrl_new[31:16];
                r_pre_cnt     <= 16'd0;
            end else if (r_enable) begin
                r_pre_cnt <= w_tick ? 16'd0 : r_pre_cnt + 16'd1;
            end

            // A bus write to COUNT overrides the tick's increment/reload.
            if (w_wr && (w_sel == c_reg_count)) begin
                r_count <= w_count_new;
            end else if (w_tick) begin
                r_count <= (w_eq && r_auto_reload) ? 32'd0 : r_count + 32'd1;
            end

            if (w_wr && (w_sel == c_reg_compare)) begin
                r_compare <= w_compare_new;
            end

            if (w_tick && w_eq) begin
                r_match <= 1'b1;
            end else if (w_wr && (w_sel == c_reg_status) && select[0] && data_i[0]) begin
                r_match <= 1'b0;
            end
        end
    end

    assign irq_o = r_match && r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_timer_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_mmio
// Brief    : Scoreboard testbench for timer_mmio using directed bus vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_mmio;

    localparam logic [31:0] c_base   = 32'h0000_8000;
    localparam logic [31:0] c_ctrl   = c_base + 32'h0;
    localparam logic [31:0] c_count  = c_base + 32'h4;
    localparam logic [31:0] c_cmp    = c_base + 32'h8;
    localparam logic [31:0] c_status = c_base + 32'hC;

    typedef struct {
        logic [31:0] d;
        logic        i;
        bit          ci;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_en = 1'b0;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [3:0]  select = 4'd0;
    logic [31:0] data_i = 32'd0;
    logic [31:0] data_o;
    logic        irq_o;

    exp_t exp_q[$];
    bit   issued = 1'b0;
    bit   issue_d = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    timer_mmio #(.BASE_ADDR(c_base)) dut (
        .clk      (clk),
        .rst      (rst),
        .ram_en   (ram_en),
        .write_en (write_en),
        .read_en  (read_en),
        .addr     (addr),
        .select   (select),
        .data_i   (data_i),
        .data_o   (data_o),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) issue_d <= issued;

    // Monitor: each bus cycle's response appears one edge later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (issue_d) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_underflow: response with no expectation, data_o=%h", data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (data_o !== e.d) begin
                        n_fail++;
                        $display("FAIL %s data: got %h expected %h", e.name, data_o, e.d);
                    end
                    if (e.ci) begin
                        n_checks++;
                        if (irq_o !== e.i) begin
                            n_fail++;
                            $display("FAIL %s irq: got %b expected %b", e.name, irq_o, e.i);
                        end
                    end
                end
            end
        end
    end

    task automatic op(input logic r, input logic e, input logic we, input logic re,
                      input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      input logic [31:0] exp_d, input bit ci, input logic ei, input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; ram_en = e; write_en = we; read_en = re;
        addr = a; select = s; data_i = d;
        x.d = exp_d; x.i = ei; x.ci = ci; x.name = nm;
        exp_q.push_back(x);
        issued = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      input bit ci, input logic ei, input string nm);
        op(1'b0, 1'b1, 1'b1, 1'b0, a, s, d, 32'd0, ci, ei, nm);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_d,
                      input bit ci, input logic ei, input string nm);
        op(1'b0, 1'b1, 1'b0, 1'b1, a, 4'hF, 32'd0, exp_d, ci, ei, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ram_en = 1'b0; write_en = 1'b0; read_en = 1'b0;
        addr = 32'd0; select = 4'd0; data_i = 32'd0;
        issued = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        rd(c_ctrl,   32'd0, 1, 1'b0, "reset_ctrl");
        rd(c_count,  32'd0, 1, 1'b0, "reset_count");
        rd(c_cmp,    32'd0, 1, 1'b0, "reset_compare");
        rd(c_status, 32'd0, 1, 1'b0, "reset_status");

        // Compare match without reload; CTRL written in cycle T
        do_reset();
        wr(c_cmp, 4'hF, 32'd5, 0, 1'b0, "cmp5_wr");
        wr(c_ctrl, 4'hF, 32'h0000_0005, 0, 1'b0, "ctrl_en_irq");
        for (int j = 1; j <= 8; j++)
            rd(c_count, j - 1, 1, (j >= 6), "count_noreload");
        rd(c_status, 32'd1, 1, 1'b1, "status_match");

        // Byte-lane writes, address low bits ignored, CTRL reserved bits
        do_reset();
        wr(c_cmp, 4'b0010, 32'hAABB_CCDD, 0, 1'b0, "cmp_lane1_wr");
        rd(c_cmp, 32'h0000_CC00, 0, 1'b0, "cmp_lane1");
        wr(c_cmp, 4'hF, 32'h1234_5678, 0, 1'b0, "cmp_full_wr");
        rd(c_cmp + 32'd3, 32'h1234_5678, 0, 1'b0, "cmp_full");
        wr(c_ctrl, 4'hF, 32'hFFFF_FFF8, 0, 1'b0, "ctrl_rsvd_wr");
        rd(c_ctrl, 32'hFFFF_0000, 0, 1'b0, "ctrl_rsvd");

        // Prescale 3: one increment per 4 cycles, CTRL write restarts period
        do_reset();
        wr(c_ctrl, 4'hF, 32'h0003_0001, 0, 1'b0, "ctrl_ps3");
        for (int j = 1; j <= 6; j++)
            rd(c_count, (j - 1) / 4, 0, 1'b0, "count_ps3");
        wr(c_ctrl, 4'hF, 32'h0003_0001, 0, 1'b0, "ctrl_ps3_restart");
        for (int j = 1; j <= 5; j++)
            rd(c_count, 1 + (j - 1) / 4, 0, 1'b0, "count_ps3_restart");
        rd(c_ctrl, 32'h0003_0001, 0, 1'b0, "ctrl_ps3_rb");

        // Auto-reload with irq disabled
        do_reset();
        wr(c_cmp, 4'hF, 32'd2, 0, 1'b0, "cmp2_wr");
        wr(c_ctrl, 4'hF, 32'h0000_0003, 0, 1'b0, "ctrl_reload");
        for (int j = 1; j <= 7; j++)
            rd(c_count, (j - 1) % 3, 1, 1'b0, "count_reload");
        rd(c_status, 32'd1, 1, 1'b0, "status_reload");

        // Write-1-to-clear collides with match set, then clears later
        do_reset();
        wr(c_cmp, 4'hF, 32'd3, 0, 1'b0, "cmp3_wr");
        wr(c_ctrl, 4'hF, 32'h0000_0005, 0, 1'b0, "ctrl_w1c");
        for (int j = 1; j <= 3; j++)
            rd(c_count, j - 1, 1, 1'b0, "count_w1c");
        wr(c_status, 4'hF, 32'd1, 1, 1'b1, "w1c_vs_set");
        rd(c_status, 32'd1, 1, 1'b1, "status_set_wins");
        wr(c_status, 4'hF, 32'd1, 1, 1'b0, "w1c_clear");
        rd(c_status, 32'd0, 1, 1'b0, "status_cleared");

        // Misses leave registers alone; reset kills an in-flight read
        do_reset();
        wr(c_cmp, 4'hF, 32'h1111_2222, 0, 1'b0, "cmp_miss_setup");
        wr(c_base + 32'h18, 4'hF, 32'hFFFF_FFFF, 0, 1'b0, "miss_wr_window");
        op(1'b0, 1'b0, 1'b1, 1'b0, c_cmp, 4'hF, 32'hFFFF_FFFF, 32'd0, 0, 1'b0, "miss_wr_noen");
        rd(c_base + 32'h10, 32'd0, 1, 1'b0, "miss_rd");
        rd(c_cmp, 32'h1111_2222, 0, 1'b0, "cmp_after_miss");
        op(1'b1, 1'b1, 1'b0, 1'b1, c_cmp, 4'hF, 32'd0, 32'd0, 1, 1'b0, "rd_under_reset");
        rd(c_cmp, 32'd0, 0, 1'b0, "cmp_after_reset");

        // Simultaneous read and write: write wins, data_o is 0
        do_reset();
        op(1'b0, 1'b1, 1'b1, 1'b1, c_count, 4'hF, 32'hDEAD_BEEF, 32'd0, 0, 1'b0, "rdwr_count");
        rd(c_count, 32'hDEAD_BEEF, 0, 1'b0, "count_after_rdwr");

        @(negedge clk);
        ram_en = 1'b0; write_en = 1'b0; read_en = 1'b0;
        issued = 1'b0;
        repeat (3) @(negedge clk);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
